// File: rtl/mem_interface_ctrl.sv
// Registered CPU-to-synchronous-RAM bridge: base-address decode, programmable
// read latency, ready/busy handshake, one-cycle write strobe and illegal-command flag.
module mem_interface_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int SEL_W  = 1,
  parameter int BASE   = 0,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [1:0]              mem_cmd,
  input  logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    ready,
  output logic                    busy,
  output logic                    err,
  output logic [ADDR_W-SEL_W-1:0] ram_addr,
  output logic [DATA_W-1:0]       ram_wdata,
  output logic                    ram_we,
  input  logic [DATA_W-1:0]       ram_rdata
);
  localparam int RA_W  = ADDR_W - SEL_W;
  localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  if (RD_LAT < 1) begin : g_chk_lat
    $error("mem_interface_ctrl: RD_LAT must be at least 1");
  end
  if (SEL_W < 1 || SEL_W >= ADDR_W) begin : g_chk_sel
    $error("mem_interface_ctrl: SEL_W must be in 1..ADDR_W-1");
  end

  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_ILL   = 2'b11;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             hit, rd_go, wr_go, ill_go, rd_last;

  assign hit = (mem_addr[ADDR_W-1 -: SEL_W] == SEL_W'(BASE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Command inputs are only looked at in IDLE; later states run on latched values.
  always_comb begin
    state_nxt = state;
    rd_go     = 1'b0;
    wr_go     = 1'b0;
    ill_go    = 1'b0;
    rd_last   = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          case (mem_cmd)
            CMD_READ:  begin rd_go = 1'b1; state_nxt = RD_WAIT; end
            CMD_WRITE: begin wr_go = 1'b1; state_nxt = WR;      end
            CMD_ILL:   ill_go = 1'b1;
            default:   ;
          endcase
        end
      end
      RD_WAIT: begin
        if (cnt == CNT_W'(1)) begin
          rd_last   = 1'b1;
          state_nxt = DONE;
        end
      end
      WR:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      err       <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      cpu_rdata <= '0;
    end else begin
      err <= ill_go;
      if (rd_go)                 cnt <= CNT_W'(RD_LAT);
      else if (state == RD_WAIT) cnt <= cnt - CNT_W'(1);
      if (rd_go || wr_go)        ram_addr  <= mem_addr[RA_W-1:0];
      if (wr_go)                 ram_wdata <= cpu_wdata;
      if (rd_last)               cpu_rdata <= ram_rdata;
    end
  end

  // Moore outputs: the write strobe and handshake fall with the async reset.
  assign ram_we = (state == WR);
  assign ready  = (state == DONE);
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_mem_interface_ctrl.sv
// Bench for mem_interface_ctrl: three instances (read latency 1, 2, 3), each with
// its own RAM model, checked against a transaction-level reference model.
module tb_mem_interface_ctrl;
  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  mem_cmd   [N];
  logic [8:0]  mem_addr  [N];
  logic [15:0] cpu_wdata [N];
  logic [15:0] cpu_rdata [N];
  logic [15:0] ram_wdata [N];
  logic [15:0] ram_rdata [N];
  logic [7:0]  ram_addr  [N];
  logic        ready [N], busy [N], err [N], ram_we [N];

  logic [15:0] ref_mem   [N][256];
  logic [15:0] exp_rdata [N];
  int n_chk = 0, n_pass = 0;

  typedef struct {
    int rdy_at, rdy_cnt, busy_cnt, we_at, we_cnt, err_at, err_cnt;
    logic [7:0]  we_addr;
    logic [15:0] we_data;
  } obs_t;

  always #5 clk = ~clk;

  function automatic logic [15:0] init_word(int g, int a);
    return 16'((a * 40503 + g * 7919) ^ 16'h5A5A);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [15:0] ram [256];
    mem_interface_ctrl #(.RD_LAT(g + 1)) u_dut (
      .clk(clk), .reset_n(reset_n), .mem_cmd(mem_cmd[g]), .mem_addr(mem_addr[g]),
      .cpu_wdata(cpu_wdata[g]), .cpu_rdata(cpu_rdata[g]), .ready(ready[g]),
      .busy(busy[g]), .err(err[g]), .ram_addr(ram_addr[g]), .ram_wdata(ram_wdata[g]),
      .ram_we(ram_we[g]), .ram_rdata(ram_rdata[g]));
    initial for (int a = 0; a < 256; a++) ram[a] = init_word(g, a);
    assign ram_rdata[g] = ram[ram_addr[g]];
    always @(posedge clk) if (ram_we[g]) ram[ram_addr[g]] <= ram_wdata[g];
  end

  // Runs ncyc cycles sampling 1 time unit after each rising edge; records only.
  task automatic run_obs(input int g, input int ncyc, input bit drop_rdy, input bit one_shot,
                         output obs_t o);
    o = '{default: 0};
    for (int i = 1; i <= ncyc; i++) begin
      @(posedge clk); #1;
      if (busy[g]) o.busy_cnt++;
      if (ready[g]) begin
        o.rdy_cnt++;
        if (o.rdy_at == 0) o.rdy_at = i;
        if (drop_rdy) mem_cmd[g] = 2'b00;
      end
      if (ram_we[g]) begin
        o.we_cnt++;
        if (o.we_at == 0) begin o.we_at = i; o.we_addr = ram_addr[g]; o.we_data = ram_wdata[g]; end
      end
      if (err[g]) begin o.err_cnt++; if (o.err_at == 0) o.err_at = i; end
      if (one_shot && i == 1) mem_cmd[g] = 2'b00;
    end
    mem_cmd[g] = 2'b00;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; #1;
    for (int g = 0; g < N; g++) begin
      n_chk++; if ({busy[g], ready[g], err[g], ram_we[g]} !== 4'b0) $display("FAIL por_ctrl[%0d] got=%b exp=0000", g, {busy[g], ready[g], err[g], ram_we[g]}); else n_pass++;
      n_chk++; if ({cpu_rdata[g], ram_wdata[g], ram_addr[g]} !== 40'h0) $display("FAIL por_data[%0d] got=%h exp=0", g, {cpu_rdata[g], ram_wdata[g], ram_addr[g]}); else n_pass++;
    end
    @(negedge clk); reset_n = 1'b1;
    // reset in the middle of a latency-3 read
    mem_cmd[2] = 2'b01; mem_addr[2] = 9'h033;
    @(posedge clk); #1; @(posedge clk); #2;
    n_chk++; if (busy[2] !== 1'b1) $display("FAIL rd_wait_busy got=%b exp=1", busy[2]); else n_pass++;
    reset_n = 1'b0; #1;
    n_chk++; if ({busy[2], ready[2], err[2], ram_we[2]} !== 4'b0) $display("FAIL midrd_rst_ctrl got=%b exp=0000", {busy[2], ready[2], err[2], ram_we[2]}); else n_pass++;
    n_chk++; if ({cpu_rdata[2], ram_addr[2], ram_wdata[2]} !== 40'h0) $display("FAIL midrd_rst_data got=%h exp=0", {cpu_rdata[2], ram_addr[2], ram_wdata[2]}); else n_pass++;
    mem_cmd[2] = 2'b00;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    n_chk++; if ({busy[2], ready[2]} !== 2'b00) $display("FAIL post_rst_idle got=%b exp=00", {busy[2], ready[2]}); else n_pass++;
    // reset while the write strobe is high: strobe must drop at once, RAM untouched
    mem_cmd[0] = 2'b10; mem_addr[0] = 9'h07F; cpu_wdata[0] = 16'hDEAD;
    @(posedge clk); #1;
    n_chk++; if (ram_we[0] !== 1'b1) $display("FAIL wr_strobe_pre got=%b exp=1", ram_we[0]); else n_pass++;
    #1 reset_n = 1'b0; #1;
    n_chk++; if (ram_we[0] !== 1'b0) $display("FAIL wr_strobe_rst got=%b exp=0", ram_we[0]); else n_pass++;
    mem_cmd[0] = 2'b00;
    @(negedge clk); reset_n = 1'b1;
    for (int g = 0; g < N; g++) exp_rdata[g] = 16'h0;
  endtask

  task automatic test_write_readback();
    obs_t o;
    mem_cmd[0] = 2'b10; mem_addr[0] = 9'h005; cpu_wdata[0] = 16'hBEEF;
    run_obs(0, 5, 1'b1, 1'b0, o);
    n_chk++; if (o.we_at !== 1 || o.we_cnt !== 1) $display("FAIL wr_we got_at=%0d cnt=%0d exp_at=1 cnt=1", o.we_at, o.we_cnt); else n_pass++;
    n_chk++; if (o.we_addr !== 8'h05 || o.we_data !== 16'hBEEF) $display("FAIL wr_addr_data got=%h/%h exp=05/beef", o.we_addr, o.we_data); else n_pass++;
    n_chk++; if (o.rdy_at !== 2 || o.rdy_cnt !== 1 || o.busy_cnt !== 2) $display("FAIL wr_handshake got rdy_at=%0d rdy_cnt=%0d busy=%0d exp 2/1/2", o.rdy_at, o.rdy_cnt, o.busy_cnt); else n_pass++;
    n_chk++; if (cpu_rdata[0] !== exp_rdata[0]) $display("FAIL wr_keeps_rdata got=%h exp=%h", cpu_rdata[0], exp_rdata[0]); else n_pass++;
    ref_mem[0][8'h05] = 16'hBEEF;
    mem_cmd[0] = 2'b01; mem_addr[0] = 9'h005;
    run_obs(0, 5, 1'b1, 1'b0, o);
    exp_rdata[0] = 16'hBEEF;
    n_chk++; if (o.rdy_at !== 2 || o.we_cnt !== 0) $display("FAIL rb_timing got rdy_at=%0d we=%0d exp 2/0", o.rdy_at, o.we_cnt); else n_pass++;
    n_chk++; if (cpu_rdata[0] !== 16'hBEEF) $display("FAIL rb_data got=%h exp=beef", cpu_rdata[0]); else n_pass++;
  endtask

  task automatic test_latency();
    obs_t o;
    mem_cmd[2] = 2'b01; mem_addr[2] = 9'h010;
    run_obs(2, 8, 1'b1, 1'b0, o);
    exp_rdata[2] = ref_mem[2][8'h10];
    n_chk++; if (o.busy_cnt !== 4) $display("FAIL lat3_busy got=%0d exp=4", o.busy_cnt); else n_pass++;
    n_chk++; if (o.rdy_at !== 4 || o.rdy_cnt !== 1) $display("FAIL lat3_ready got_at=%0d cnt=%0d exp_at=4 cnt=1", o.rdy_at, o.rdy_cnt); else n_pass++;
    n_chk++; if (cpu_rdata[2] !== exp_rdata[2]) $display("FAIL lat3_data got=%h exp=%h", cpu_rdata[2], exp_rdata[2]); else n_pass++;
  endtask

  task automatic test_decode_miss();
    obs_t o;
    mem_cmd[0] = 2'b01; mem_addr[0] = 9'h105;
    run_obs(0, 4, 1'b0, 1'b0, o);
    n_chk++; if (o.busy_cnt !== 0 || o.rdy_cnt !== 0 || o.we_cnt !== 0) $display("FAIL miss_rd got busy=%0d rdy=%0d we=%0d exp 0/0/0", o.busy_cnt, o.rdy_cnt, o.we_cnt); else n_pass++;
    n_chk++; if (cpu_rdata[0] !== exp_rdata[0]) $display("FAIL miss_rdata got=%h exp=%h", cpu_rdata[0], exp_rdata[0]); else n_pass++;
    mem_cmd[0] = 2'b10; mem_addr[0] = 9'h1FF; cpu_wdata[0] = 16'h1111;
    run_obs(0, 4, 1'b0, 1'b0, o);
    n_chk++; if (o.busy_cnt !== 0 || o.we_cnt !== 0) $display("FAIL miss_wr got busy=%0d we=%0d exp 0/0", o.busy_cnt, o.we_cnt); else n_pass++;
  endtask

  task automatic test_illegal();
    obs_t o;
    mem_cmd[1] = 2'b11; mem_addr[1] = 9'h044;
    run_obs(1, 4, 1'b0, 1'b1, o);
    n_chk++; if (o.err_at !== 1 || o.err_cnt !== 1) $display("FAIL ill_err got_at=%0d cnt=%0d exp_at=1 cnt=1", o.err_at, o.err_cnt); else n_pass++;
    n_chk++; if (o.rdy_cnt !== 0 || o.we_cnt !== 0 || o.busy_cnt !== 0) $display("FAIL ill_side got rdy=%0d we=%0d busy=%0d exp 0/0/0", o.rdy_cnt, o.we_cnt, o.busy_cnt); else n_pass++;
    mem_cmd[1] = 2'b11; mem_addr[1] = 9'h144;
    run_obs(1, 3, 1'b0, 1'b1, o);
    n_chk++; if (o.err_cnt !== 0) $display("FAIL ill_miss_err got=%0d exp=0", o.err_cnt); else n_pass++;
  endtask

  task automatic test_ignore_busy();
    int rdy_at = 0, we_cnt = 0;
    mem_cmd[1] = 2'b01; mem_addr[1] = 9'h020;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin mem_addr[1] = 9'h0AA; mem_cmd[1] = 2'b10; cpu_wdata[1] = 16'h1234; end
      if (ram_we[1]) we_cnt++;
      if (ready[1] && rdy_at == 0) begin rdy_at = i; mem_cmd[1] = 2'b00; end
    end
    mem_cmd[1] = 2'b00;
    exp_rdata[1] = ref_mem[1][8'h20];
    n_chk++; if (rdy_at !== 3) $display("FAIL ign_ready got=%0d exp=3", rdy_at); else n_pass++;
    n_chk++; if (cpu_rdata[1] !== exp_rdata[1]) $display("FAIL ign_data got=%h exp=%h", cpu_rdata[1], exp_rdata[1]); else n_pass++;
    n_chk++; if (we_cnt !== 0 || ram_addr[1] !== 8'h20) $display("FAIL ign_nowrite got we=%0d addr=%h exp 0/20", we_cnt, ram_addr[1]); else n_pass++;
  endtask

  task automatic test_held_cmd();
    logic [6:0] rdy_v = '0, busy_v = '0;
    mem_cmd[0] = 2'b01; mem_addr[0] = 9'h030;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      rdy_v[i-1]  = ready[0];
      busy_v[i-1] = busy[0];
    end
    mem_cmd[0] = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    exp_rdata[0] = ref_mem[0][8'h30];
    n_chk++; if (rdy_v !== 7'b0010010) $display("FAIL held_ready got=%b exp=0010010", rdy_v); else n_pass++;
    n_chk++; if (busy_v !== 7'b1011011) $display("FAIL held_busy got=%b exp=1011011", busy_v); else n_pass++;
    n_chk++; if (cpu_rdata[0] !== exp_rdata[0] || busy[0] !== 1'b0) $display("FAIL held_end got=%h/%b exp=%h/0", cpu_rdata[0], busy[0], exp_rdata[0]); else n_pass++;
  endtask

  task automatic test_random();
    obs_t o;
    for (int g = 0; g < N; g++) begin
      for (int t = 0; t < 30; t++) begin
        logic [1:0]  cmd  = 2'($urandom_range(0, 3));
        logic [8:0]  addr = {($urandom_range(0, 3) == 0), 8'($urandom)};
        logic [15:0] data = 16'($urandom);
        bit hit = (addr[8] == 1'b0);
        bit rd = hit && cmd == 2'b01, wr = hit && cmd == 2'b10, il = hit && cmd == 2'b11;
        int lat = g + 1;
        int e_rdy = rd ? lat + 1 : (wr ? 2 : 0);
        int e_busy = e_rdy;
        mem_cmd[g] = cmd; mem_addr[g] = addr; cpu_wdata[g] = data;
        run_obs(g, lat + 4, rd || wr, !(rd || wr), o);
        if (rd) exp_rdata[g] = ref_mem[g][addr[7:0]];
        n_chk++; if (o.rdy_at !== e_rdy || o.rdy_cnt !== (e_rdy != 0 ? 1 : 0)) $display("FAIL rnd_ready[%0d.%0d] cmd=%b addr=%h got_at=%0d exp_at=%0d", g, t, cmd, addr, o.rdy_at, e_rdy); else n_pass++;
        n_chk++; if (o.busy_cnt !== e_busy) $display("FAIL rnd_busy[%0d.%0d] got=%0d exp=%0d", g, t, o.busy_cnt, e_busy); else n_pass++;
        n_chk++; if (o.we_cnt !== (wr ? 1 : 0) || o.err_cnt !== (il ? 1 : 0)) $display("FAIL rnd_we_err[%0d.%0d] got we=%0d err=%0d exp we=%0d err=%0d", g, t, o.we_cnt, o.err_cnt, wr, il); else n_pass++;
        if (wr) begin
          n_chk++; if (o.we_addr !== addr[7:0] || o.we_data !== data) $display("FAIL rnd_wr[%0d.%0d] got=%h/%h exp=%h/%h", g, t, o.we_addr, o.we_data, addr[7:0], data); else n_pass++;
          ref_mem[g][addr[7:0]] = data;
        end
        n_chk++; if (cpu_rdata[g] !== exp_rdata[g]) $display("FAIL rnd_rdata[%0d.%0d] got=%h exp=%h", g, t, cpu_rdata[g], exp_rdata[g]); else n_pass++;
      end
    end
  endtask

  initial begin
    for (int g = 0; g < N; g++) begin
      mem_cmd[g] = 2'b00; mem_addr[g] = '0; cpu_wdata[g] = '0; exp_rdata[g] = '0;
      for (int a = 0; a < 256; a++) ref_mem[g][a] = init_word(g, a);
    end
    #2;
    test_reset();
    test_write_readback();
    test_latency();
    test_decode_miss();
    test_illegal();
    test_ignore_busy();
    test_held_cmd();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
